// File: rtl/chirp_sequencer_if.sv
// Control, status and DDS handshake bundle for chirp_sequencer.
// master = sequencer side, slave = host/DDS side.
interface chirp_sequencer_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 seq_start;
  logic                 seq_abort;
  logic [15:0]          num_chirps;
  logic [CNT_WIDTH-1:0] chirp_period;
  logic [15:0]          adc_pre_cycles;
  logic [15:0]          adc_post_cycles;
  logic                 chirp_ready;
  logic                 chirp_done;
  logic                 chirp_init;
  logic                 chirp_enable;
  logic                 adc_enable;
  logic                 seq_busy;
  logic                 seq_done;
  logic [15:0]          chirp_index;
  logic                 timeout_err;
  logic                 pri_overrun;

  modport master (
    input  seq_start, seq_abort, num_chirps, chirp_period,
    input  adc_pre_cycles, adc_post_cycles,
    input  chirp_ready, chirp_done,
    output chirp_init, chirp_enable, adc_enable,
    output seq_busy, seq_done, chirp_index,
    output timeout_err, pri_overrun
  );

  modport slave (
    output seq_start, seq_abort, num_chirps, chirp_period,
    output adc_pre_cycles, adc_post_cycles,
    output chirp_ready, chirp_done,
    input  chirp_init, chirp_enable, adc_enable,
    input  seq_busy, seq_done, chirp_index,
    input  timeout_err, pri_overrun
  );
endinterface

// File: rtl/chirp_sequencer.sv
// Radar pulse scheduler: sequences DDS chirps and ADC capture
// windows at a fixed PRI, with abort, timeout and overrun status.
module chirp_sequencer #(
  parameter int CNT_WIDTH      = 32,
  parameter int DDS_LATENCY    = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk_245,
  input  logic clk_245_rst,
  chirp_sequencer_if.master sif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_WAIT,
    S_PRE,
    S_CHIRP,
    S_POST,
    S_GAP,
    S_DONE
  } state_e;

  state_e               state_q;
  logic [15:0]          num_q;
  logic [15:0]          pre_q;
  logic [15:0]          post_q;
  logic [15:0]          idx_q;
  logic [CNT_WIDTH-1:0] per_q;
  logic [CNT_WIDTH-1:0] pri_q;
  logic [31:0]          tmo_q;
  logic [16:0]          ph_q;
  logic                 gap_first_q;
  logic                 init_q;
  logic                 cen_q;
  logic                 aen_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 terr_q;
  logic                 povr_q;

  logic [CNT_WIDTH-1:0] pri_thr_d;
  logic [16:0]          pre_end_d;
  logic [16:0]          post_tot_d;
  logic [16:0]          post_end_d;
  logic                 pri_due_d;
  logic                 last_d;
  logic                 tmo_hit_d;

  // Zero-length windows still occupy one cycle in their state.
  always_comb begin
    pri_thr_d  = (per_q == '0) ? '0 : per_q - CNT_WIDTH'(1);
    pre_end_d  = (pre_q == 16'd0) ? 17'd0
               : {1'b0, pre_q} - 17'd1;
    post_tot_d = {1'b0, post_q} + 17'(DDS_LATENCY);
    post_end_d = (post_tot_d == 17'd0) ? 17'd0
               : post_tot_d - 17'd1;
    pri_due_d  = (pri_q >= pri_thr_d);
    last_d     = (num_q != 16'd0) && (idx_q + 16'd1 == num_q);
    tmo_hit_d  = (tmo_q >= 32'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk_245) begin
    if (clk_245_rst) begin
      state_q     <= S_IDLE;
      num_q       <= '0;
      pre_q       <= '0;
      post_q      <= '0;
      idx_q       <= '0;
      per_q       <= '0;
      pri_q       <= '0;
      tmo_q       <= '0;
      ph_q        <= '0;
      gap_first_q <= 1'b0;
      init_q      <= 1'b0;
      cen_q       <= 1'b0;
      aen_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      terr_q      <= 1'b0;
      povr_q      <= 1'b0;
    end else begin
      init_q <= 1'b0;
      done_q <= 1'b0;
      tmo_q  <= tmo_q + 32'd1;
      ph_q   <= ph_q + 17'd1;
      if (pri_q != '1) pri_q <= pri_q + CNT_WIDTH'(1);

      if (state_q != S_IDLE && state_q != S_DONE && sif.seq_abort) begin
        cen_q   <= 1'b0;
        aen_q   <= 1'b0;
        done_q  <= 1'b1;
        state_q <= S_DONE;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (sif.seq_start && !sif.seq_abort) begin
              num_q   <= sif.num_chirps;
              per_q   <= sif.chirp_period;
              pre_q   <= sif.adc_pre_cycles;
              post_q  <= sif.adc_post_cycles;
              idx_q   <= '0;
              terr_q  <= 1'b0;
              povr_q  <= 1'b0;
              pri_q   <= '0;
              init_q  <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= S_INIT;
            end
          end
          S_INIT: begin
            tmo_q   <= '0;
            state_q <= S_WAIT;
          end
          S_WAIT: begin
            if (sif.chirp_ready) begin
              aen_q   <= 1'b1;
              ph_q    <= '0;
              state_q <= S_PRE;
            end else if (tmo_hit_d) begin
              terr_q  <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
          S_PRE: begin
            if (ph_q >= pre_end_d) begin
              cen_q   <= 1'b1;
              tmo_q   <= '0;
              state_q <= S_CHIRP;
            end
          end
          S_CHIRP: begin
            if (sif.chirp_done) begin
              cen_q   <= 1'b0;
              ph_q    <= '0;
              state_q <= S_POST;
            end else if (tmo_hit_d) begin
              cen_q   <= 1'b0;
              aen_q   <= 1'b0;
              terr_q  <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
          S_POST: begin
            if (ph_q >= post_end_d) begin
              aen_q       <= 1'b0;
              gap_first_q <= 1'b1;
              state_q     <= S_GAP;
            end
          end
          S_GAP: begin
            gap_first_q <= 1'b0;
            if (last_d) begin
              idx_q   <= idx_q + 16'd1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else if (pri_due_d) begin
              // PRI already spent on arrival: the next chirp is late.
              if (gap_first_q) povr_q <= 1'b1;
              idx_q   <= idx_q + 16'd1;
              pri_q   <= '0;
              init_q  <= 1'b1;
              state_q <= S_INIT;
            end
          end
          S_DONE: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign sif.chirp_init   = init_q;
  assign sif.chirp_enable = cen_q;
  assign sif.adc_enable   = aen_q;
  assign sif.seq_busy     = busy_q;
  assign sif.seq_done     = done_q;
  assign sif.chirp_index  = idx_q;
  assign sif.timeout_err  = terr_q;
  assign sif.pri_overrun  = povr_q;

endmodule

// File: doc/chirp_sequencer.md
Name: chirp_sequencer

Overview:
Radar-pulse scheduler for the chirp DDS / ADC capture datapath in the 245.76 MHz domain.
- Generates chirp_init, chirp_enable and adc_enable toward the DDS and capture logic.
- Repeats a programmed number of chirps at a fixed pulse-repetition interval (PRI).
- Provides abort, handshake timeout, PRI-overrun detection and status.

Parameters:
- CNT_WIDTH, 32, width of PRI and elapsed-cycle counters.
- DDS_LATENCY, 2, extra cycles adc_enable is held after the post window to flush the DDS/DAC/ADC pipeline.
- TIMEOUT_CYCLES, 65535, maximum cycles spent in WAIT_READY or CHIRP before error.

Ports:
- clk_245  in  1  sample clock; all logic on rising edge.
- clk_245_rst  in  1  reset, synchronous, active-high.
- seq_start  in  1  one-cycle start pulse; ignored unless IDLE.
- seq_abort  in  1  level; stops the sequence.
- num_chirps  in  16  chirps per sequence; 0 = continuous until abort.
- chirp_period  in  CNT_WIDTH  PRI in cycles, measured from chirp_init to the next chirp_init.
- adc_pre_cycles  in  16  cycles adc_enable leads chirp_enable.
- adc_post_cycles  in  16  cycles adc_enable trails chirp_done, before the DDS_LATENCY flush.
- chirp_ready  in  1  DDS ready for chirp.
- chirp_done  in  1  DDS chirp finished (pulse or level).
- chirp_init  out  1  one-cycle DDS init pulse.
- chirp_enable  out  1  DDS run enable.
- adc_enable  out  1  capture enable; its falling edge closes a capture frame.
- seq_busy  out  1  high in every state except IDLE.
- seq_done  out  1  one-cycle pulse at sequence end: normal, abort or timeout.
- chirp_index  out  16  index of current chirp, 0-based.
- timeout_err  out  1  sticky; cleared by seq_start or reset.
- pri_overrun  out  1  sticky; cleared by seq_start or reset.

Behaviour:
- All outputs registered. Reset (clk_245_rst=1) forces state IDLE and drives every output and counter to 0; this takes priority over all other inputs, including mid-chirp.
- Configuration inputs are latched on the accepted seq_start; later changes have no effect until the next start.
- States and transitions:
  - IDLE: on seq_start go to INIT; clear chirp_index and the sticky flags.
  - INIT: chirp_init=1 for exactly one cycle, i.e. the cycle after seq_start, or the cycle after GAP exits. The PRI counter resets to 0 this cycle. Next state WAIT_READY.
  - WAIT_READY: when chirp_ready is sampled 1, go to ADC_PRE. adc_enable=1 from the next cycle.
  - ADC_PRE: hold for adc_pre_cycles cycles. If the value is 0, pass through in one cycle. Then go to CHIRP.
  - CHIRP: chirp_enable=1 from the cycle after entry. When chirp_done is sampled 1, chirp_enable=0 next cycle; go to ADC_POST.
  - ADC_POST: hold adc_enable for adc_post_cycles+DDS_LATENCY cycles, then adc_enable=0; go to GAP.
  - GAP: increment chirp_index. If the last chirp is complete (chirp_index+1==num_chirps, num_chirps!=0), go to DONE. Otherwise wait until PRI counter >= chirp_period-1, then go to INIT.
  - DONE: seq_done=1 for one cycle; go to IDLE.
- PRI overrun: if GAP is entered with PRI counter already >= chirp_period-1, set pri_overrun and go to INIT next cycle (no gap). chirp_period of 0 or 1 therefore always overruns.
- PRI counter saturates at all-ones and does not wrap.
- Timeout: a cycle counter resets on entry to WAIT_READY and to CHIRP. Reaching TIMEOUT_CYCLES in either state causes:
  - chirp_enable=0 and adc_enable=0 next cycle;
  - timeout_err=1;
  - go to DONE.
- Abort: seq_abort sampled 1 in any non-IDLE state drops chirp_enable and adc_enable next cycle and goes to DONE. No further chirp_init is issued. Abort wins over a simultaneous chirp_done, chirp_ready or timeout. In IDLE, abort has no effect, and seq_start with seq_abort both 1 is ignored.
- chirp_index wraps 0xFFFF→0 in continuous mode.
- chirp_enable never asserts without adc_enable=1. adc_enable never deasserts while chirp_enable=1.

Test Plan:
1. num_chirps=3, chirp_period=200, pre=4, post=3, DDS model: ready 2 cycles after init, done 50 cycles after enable → three chirp_init pulses exactly 200 cycles apart. Each adc_enable leads chirp_enable by 4 cycles and trails chirp_done by 5 (post 3 + DDS_LATENCY 2). seq_done 1 cycle after the third GAP; pri_overrun=0.
2. chirp_period=40 with a 50-cycle chirp → pri_overrun=1; the next chirp_init comes one cycle after GAP entry; all chirps are still issued.
3. chirp_ready held 0, TIMEOUT_CYCLES=100 → timeout_err=1 and seq_done at cycle 100 of WAIT_READY; adc_enable never asserted.
4. seq_abort pulsed 10 cycles into CHIRP of chirp 1 (num_chirps=0) → chirp_enable and adc_enable low next cycle, seq_done pulse, no further chirp_init, chirp_index=1.
5. clk_245_rst asserted mid-ADC_POST → all outputs 0 next cycle; a subsequent seq_start runs normally with flags cleared.
6. pre=0, post=0 → adc_enable and chirp_enable rise on consecutive cycles; adc_enable falls 2 cycles after chirp_enable falls.
